// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RV32I control path: opcodes, FSM
// states, ALU operation codes and datapath mux select codes. Also provides
// the per-state control word used by the controller FSM.
package riscv_pkg;

   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECUTER = 4'd6,
      EXECUTEI = 4'd7,
      ALUWB    = 4'd8,
      BEQ      = 4'd9,
      JAL      = 4'd10
   } state_t;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluop_t;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLT = 3'b101
   } aluctl_t;

   typedef enum logic [1:0] {
      RES_ALUOUT    = 2'b00,
      RES_DATA      = 2'b01,
      RES_ALURESULT = 2'b10
   } ressrc_t;

   typedef enum logic [1:0] {
      SRCA_PC    = 2'b00,
      SRCA_OLDPC = 2'b01,
      SRCA_RD1   = 2'b10
   } srca_t;

   typedef enum logic [1:0] {
      SRCB_RD2  = 2'b00,
      SRCB_IMM  = 2'b01,
      SRCB_FOUR = 2'b10
   } srcb_t;

   typedef enum logic [1:0] {
      IMM_I = 2'b00,
      IMM_S = 2'b01,
      IMM_B = 2'b10,
      IMM_J = 2'b11
   } immsrc_t;

   typedef struct packed {
      logic    pcupdate;
      logic    branch;
      logic    adrsrc;
      logic    memwrite;
      logic    irwrite;
      logic    regwrite;
      ressrc_t resultsrc;
      srca_t   alusrca;
      srcb_t   alusrcb;
      aluop_t  aluop;
   } ctrl_t;

   // Moore control word for a state; fields not set stay zero.
   function automatic ctrl_t state_ctrl(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         FETCH: begin
            c.irwrite   = 1'b1;
            c.alusrcb   = SRCB_FOUR;
            c.resultsrc = RES_ALURESULT;
            c.pcupdate  = 1'b1;
         end
         DECODE: begin
            c.alusrca = SRCA_OLDPC;
            c.alusrcb = SRCB_IMM;
         end
         MEMADR: begin
            c.alusrca = SRCA_RD1;
            c.alusrcb = SRCB_IMM;
         end
         MEMREAD: begin
            c.adrsrc = 1'b1;
         end
         MEMWB: begin
            c.resultsrc = RES_DATA;
            c.regwrite  = 1'b1;
         end
         MEMWRITE: begin
            c.adrsrc   = 1'b1;
            c.memwrite = 1'b1;
         end
         EXECUTER: begin
            c.alusrca = SRCA_RD1;
            c.alusrcb = SRCB_RD2;
            c.aluop   = ALUOP_FUNCT;
         end
         EXECUTEI: begin
            c.alusrca = SRCA_RD1;
            c.alusrcb = SRCB_IMM;
            c.aluop   = ALUOP_FUNCT;
         end
         ALUWB: begin
            c.regwrite = 1'b1;
         end
         BEQ: begin
            c.alusrca = SRCA_RD1;
            c.alusrcb = SRCB_RD2;
            c.aluop   = ALUOP_SUB;
            c.branch  = 1'b1;
         end
         JAL: begin
            c.alusrca  = SRCA_OLDPC;
            c.alusrcb  = SRCB_FOUR;
            c.pcupdate = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Bundle between the multicycle controller and the shared datapath.
// master: controller side (takes instruction fields and zero flag, drives
//         enables, mux selects, ALU control and the exported state).
// slave:  datapath side, opposite directions.
interface multicycle_controller_if;

   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;
   logic       PCWrite;
   logic       AdrSrc;
   logic       MemWrite;
   logic       IRWrite;
   logic       RegWrite;
   logic [1:0] ResultSrc;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [2:0] ALUControl;
   logic [1:0] ImmSrc;
   logic [3:0] state;

   modport master (
      input  op, funct3, funct7b5, zero,
      output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
             ALUSrcA, ALUSrcB, ALUControl, ImmSrc, state
   );

   modport slave (
      output op, funct3, funct7b5, zero,
      input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
             ALUSrcA, ALUSrcB, ALUControl, ImmSrc, state
   );

endinterface

// File: rtl/alu_decoder.sv
// Combinational ALU operation decoder.
// Ports: aluop (add/sub/by-funct), funct3, funct7b5, op5 (instr[5], separates
//        R-type sub from I-type addi) -> alucontrol.
module alu_decoder
   import riscv_pkg::*;
(
   input  aluop_t     aluop,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       op5,
   output aluctl_t    alucontrol
);

   always_comb begin
      alucontrol = ALU_ADD;
      case (aluop)
         ALUOP_ADD: alucontrol = ALU_ADD;
         ALUOP_SUB: alucontrol = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               3'b000:  alucontrol = (funct7b5 & op5) ? ALU_SUB : ALU_ADD;
               3'b010:  alucontrol = ALU_SLT;
               3'b110:  alucontrol = ALU_OR;
               3'b111:  alucontrol = ALU_AND;
               default: alucontrol = ALU_ADD;
            endcase
         end
         default: alucontrol = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control unit: Moore FSM sequencing fetch, decode,
// execute, memory and writeback over the shared datapath.
// Ports: clk, reset (sync, active-high), bus (master modport): instruction
//        fields op/funct3/funct7b5 and zero in; write enables, mux selects,
//        ALUControl, ImmSrc and current state out.
module multicycle_controller
   import riscv_pkg::*;
(
   input logic                     clk,
   input logic                     reset,
   multicycle_controller_if.master bus
);

   state_t  state_q;
   state_t  state_n;
   ctrl_t   ctrl_q;
   aluctl_t alucontrol;

   always_comb begin
      state_n = FETCH;
      case (state_q)
         FETCH: state_n = DECODE;
         DECODE: begin
            case (bus.op)
               OP_LW, OP_SW: state_n = MEMADR;
               OP_RTYPE:     state_n = EXECUTER;
               OP_ITYPE:     state_n = EXECUTEI;
               OP_BEQ:       state_n = BEQ;
               OP_JAL:       state_n = JAL;
               default:      state_n = FETCH;
            endcase
         end
         MEMADR:   state_n = (bus.op == OP_SW) ? MEMWRITE : MEMREAD;
         MEMREAD:  state_n = MEMWB;
         EXECUTER: state_n = ALUWB;
         EXECUTEI: state_n = ALUWB;
         JAL:      state_n = ALUWB;
         default:  state_n = FETCH;
      endcase
   end

   // Control word is loaded from the next state so outputs come straight
   // from flops yet still match the current state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FETCH;
         ctrl_q  <= state_ctrl(FETCH);
      end else begin
         state_q <= state_n;
         ctrl_q  <= state_ctrl(state_n);
      end
   end

   // Enables are masked by reset directly so a reset mid-instruction
   // suppresses writes in the same cycle, not one edge later.
   assign bus.PCWrite   = ~reset & (ctrl_q.pcupdate | (ctrl_q.branch & bus.zero));
   assign bus.IRWrite   = ~reset & ctrl_q.irwrite;
   assign bus.RegWrite  = ~reset & ctrl_q.regwrite;
   assign bus.MemWrite  = ~reset & ctrl_q.memwrite;
   assign bus.AdrSrc    = ctrl_q.adrsrc;
   assign bus.ResultSrc = ctrl_q.resultsrc;
   assign bus.ALUSrcA   = ctrl_q.alusrca;
   assign bus.ALUSrcB   = ctrl_q.alusrcb;
   assign bus.state     = state_q;
   assign bus.ALUControl = alucontrol;

   alu_decoder u_alu_decoder (
      .aluop      (ctrl_q.aluop),
      .funct3     (bus.funct3),
      .funct7b5   (bus.funct7b5),
      .op5        (bus.op[5]),
      .alucontrol (alucontrol)
   );

   always_comb begin
      case (bus.op)
         OP_LW, OP_ITYPE: bus.ImmSrc = IMM_I;
         OP_SW:           bus.ImmSrc = IMM_S;
         OP_BEQ:          bus.ImmSrc = IMM_B;
         OP_JAL:          bus.ImmSrc = IMM_J;
         default:         bus.ImmSrc = IMM_I;
      endcase
   end

endmodule
